// File: rtl/key_exp_param.sv
// AES key-expansion engine for AES-128/192/256, selected by NK.
// Generates one schedule word per clock into internal storage and serves
// round keys through an indexed combinational read port.
module key_exp_param #(
   parameter int unsigned NK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [32*NK-1:0]  key,
   output logic              busy,
   output logic              done,
   output logic              key_valid,
   input  logic [3:0]        rk_idx,
   output logic [127:0]      rk
);

   localparam int unsigned NR = NK + 6;
   localparam int unsigned NW = 4 * (NR + 1);
   localparam int unsigned CW = $clog2(NW + 1);
   localparam int unsigned AW = $clog2(NW);
   localparam int unsigned MW = $clog2(NK);

   if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_nk_check
      $error("key_exp_param: NK must be 4, 6 or 8");
   end

   // ---------------------------------------------------------------
   // Finite-field helpers
   // ---------------------------------------------------------------

   // GF(2^4) multiply, field polynomial x^4 + x + 1
   function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] r;
      logic [3:0] aa;
      r  = '0;
      aa = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) r = r ^ aa;
         aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
      end
      return r;
   endfunction

   // GF(2^4) inverse as a^14; maps 0 to 0 as the S-box requires
   function automatic logic [3:0] gf4_inv(input logic [3:0] a);
      logic [3:0] a2;
      logic [3:0] a4;
      logic [3:0] a8;
      a2 = gf4_mul(a, a);
      a4 = gf4_mul(a2, a2);
      a8 = gf4_mul(a4, a4);
      return gf4_mul(gf4_mul(a2, a4), a8);
   endfunction

   // GF(2^8) multiply in the AES field (x^8 + x^4 + x^3 + x + 1)
   function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] aa;
      r  = '0;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return r;
   endfunction

   // Multiply an 8-bit vector by a constant GF(2) matrix stored column-wise
   function automatic logic [7:0] lin_map(input logic [63:0] m, input logic [7:0] x);
      logic [7:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         if (x[k]) r = r ^ m[8*k +: 8];
      end
      return r;
   endfunction

   // Smallest lambda making y^2 + y + lambda irreducible over GF(2^4)
   function automatic logic [3:0] find_lambda();
      logic [3:0] lam;
      logic       hit;
      lam = '0;
      for (int c = 15; c >= 1; c--) begin
         hit = 1'b0;
         for (int t = 0; t < 16; t++) begin
            if ((gf4_mul(4'(t), 4'(t)) ^ 4'(t)) == 4'(c)) hit = 1'b1;
         end
         if (!hit) lam = 4'(c);
      end
      return lam;
   endfunction

   // Composite-to-AES basis change: images of alpha^k and Y*alpha^k
   function automatic logic [63:0] calc_iso(input logic [3:0] lam);
      logic [7:0]  a_r;
      logic [7:0]  b_r;
      logic [7:0]  p;
      logic [7:0]  p2;
      logic [7:0]  lam8;
      logic [7:0]  apw;
      logic [63:0] m;
      a_r = '0;
      for (int c = 255; c >= 2; c--) begin
         p  = 8'(c);
         p2 = gf8_mul(p, p);
         if ((gf8_mul(p2, p2) ^ p ^ 8'h01) == 8'h00) a_r = p;
      end
      lam8 = '0;
      apw  = 8'h01;
      for (int k = 0; k < 4; k++) begin
         if (lam[k]) lam8 = lam8 ^ apw;
         apw = gf8_mul(apw, a_r);
      end
      b_r = '0;
      for (int c = 255; c >= 2; c--) begin
         p = 8'(c);
         if ((gf8_mul(p, p) ^ p ^ lam8) == 8'h00) b_r = p;
      end
      m   = '0;
      apw = 8'h01;
      for (int k = 0; k < 4; k++) begin
         m[8*k +: 8]     = apw;
         m[8*(k+4) +: 8] = gf8_mul(b_r, apw);
         apw = gf8_mul(apw, a_r);
      end
      return m;
   endfunction

   // AES-to-composite basis change: preimage of each AES unit vector
   function automatic logic [63:0] calc_iso_inv(input logic [63:0] m);
      logic [63:0] r;
      r = '0;
      for (int j = 0; j < 8; j++) begin
         for (int c = 0; c < 256; c++) begin
            if (lin_map(m, 8'(c)) == (8'h01 << j)) r[8*j +: 8] = 8'(c);
         end
      end
      return r;
   endfunction

   localparam logic [3:0]  LAM     = find_lambda();
   localparam logic [63:0] ISO     = calc_iso(LAM);
   localparam logic [63:0] ISO_INV = calc_iso_inv(ISO);

   // AES S-box: inversion in GF((2^4)^2) followed by the affine transform
   function automatic logic [7:0] sub_byte(input logic [7:0] x);
      logic [7:0] c;
      logic [3:0] h;
      logic [3:0] l;
      logic [3:0] d;
      logic [3:0] di;
      logic [7:0] v;
      c  = lin_map(ISO_INV, x);
      h  = c[7:4];
      l  = c[3:0];
      d  = gf4_mul(gf4_mul(h, h), LAM) ^ gf4_mul(h, l) ^ gf4_mul(l, l);
      di = gf4_inv(d);
      v  = lin_map(ISO, {gf4_mul(h, di), gf4_mul(h ^ l, di)});
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
               ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sub_byte(x[31:24]), sub_byte(x[23:16]), sub_byte(x[15:8]), sub_byte(x[7:0])};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // ---------------------------------------------------------------
   // State
   // ---------------------------------------------------------------
   typedef enum logic [0:0] {IDLE, RUN} state_t;

   localparam logic [MW-1:0] MOD_LAST = MW'(NK - 1);
   localparam logic [MW-1:0] MOD_HALF = MW'(NK / 2);

   state_t         state;
   state_t         state_next;
   logic           load_c;
   logic           step_c;
   logic           last_c;
   logic [CW-1:0]  wi;
   logic [MW-1:0]  mod;
   logic [7:0]     rcon;
   logic [31:0]    w_mem [NW];

   logic [31:0]    prev_c;
   logic [31:0]    old_c;
   logic [31:0]    sub_in_c;
   logic [31:0]    sub_out_c;
   logic [31:0]    temp_c;
   logic [31:0]    w_new_c;
   logic [AW-1:0]  rk_base_c;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state and per-cycle control strobes
   always_comb begin
      state_next = state;
      load_c     = 1'b0;
      step_c     = 1'b0;
      last_c     = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (start) begin
                  load_c     = 1'b1;
                  state_next = RUN;
               end
            end
            RUN: begin
               step_c = 1'b1;
               if (wi == CW'(NW - 1)) begin
                  last_c     = 1'b1;
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Word counter, modulo-NK sub-counter, rcon and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         key_valid <= 1'b0;
         wi        <= '0;
         mod       <= '0;
         rcon      <= 8'h01;
      end else begin
         done <= last_c;
         if (load_c) begin
            busy      <= 1'b1;
            key_valid <= 1'b0;
            wi        <= CW'(NK);
            mod       <= '0;
            rcon      <= 8'h01;
         end else if (step_c) begin
            wi  <= wi + CW'(1);
            mod <= (mod == MOD_LAST) ? '0 : mod + MW'(1);
            if (mod == '0) rcon <= xtime(rcon);
            if (last_c) begin
               busy      <= 1'b0;
               key_valid <= 1'b1;
            end
         end
      end
   end

   // Next schedule word from w[i-1] and w[i-NK]
   always_comb begin
      prev_c    = w_mem[AW'(wi - CW'(1))];
      old_c     = w_mem[AW'(wi - CW'(NK))];
      sub_in_c  = (mod == '0) ? {prev_c[23:0], prev_c[31:24]} : prev_c;
      sub_out_c = sub_word(sub_in_c);
      if (mod == '0)                         temp_c = sub_out_c ^ {rcon, 24'h0};
      else if ((NK == 8) && (mod == MOD_HALF)) temp_c = sub_out_c;
      else                                   temp_c = prev_c;
      w_new_c   = old_c ^ temp_c;
   end

   // Schedule storage: whole key on load, one word per RUN cycle
   always_ff @(posedge clk) begin
      if (load_c) begin
         for (int k = 0; k < NK; k++) begin
            w_mem[AW'(k)] <= key[32*(NK-1-k) +: 32];
         end
      end else if (step_c) begin
         w_mem[AW'(wi)] <= w_new_c;
      end
   end

   // Round-key read port; zero unless the schedule is complete and index legal
   always_comb begin
      rk_base_c = AW'({rk_idx, 2'b00});
      rk        = '0;
      if (key_valid && (rk_idx <= 4'(NR))) begin
         rk = {w_mem[rk_base_c],             w_mem[rk_base_c + AW'(1)],
               w_mem[rk_base_c + AW'(2)],    w_mem[rk_base_c + AW'(3)]};
      end
   end

endmodule

// File: tb/tb_key_exp_param.sv
// Directed bench for key_exp_param: one instance per key length.
module tb_key_exp_param;

   localparam logic [127:0] T1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [191:0] T2_KEY = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
   localparam logic [255:0] T3_KEY =
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] T1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    start_v;
   logic [2:0]    busy_v;
   logic [2:0]    done_v;
   logic [2:0]    kv_v;
   logic [127:0]  key4;
   logic [191:0]  key6;
   logic [255:0]  key8;
   logic [3:0]    idx_v [3];
   logic [127:0]  rk_v  [3];

   int checks = 0;
   int errors = 0;

   typedef struct {
      int           d;
      logic [3:0]   idx;
      logic [127:0] exp;
   } vec_t;

   vec_t tbl [15];

   always #5 clk = ~clk;

   key_exp_param #(.NK(4)) dut4 (
      .clk(clk), .rst(rst), .start(start_v[0]), .key(key4), .busy(busy_v[0]),
      .done(done_v[0]), .key_valid(kv_v[0]), .rk_idx(idx_v[0]), .rk(rk_v[0]));
   key_exp_param #(.NK(6)) dut6 (
      .clk(clk), .rst(rst), .start(start_v[1]), .key(key6), .busy(busy_v[1]),
      .done(done_v[1]), .key_valid(kv_v[1]), .rk_idx(idx_v[1]), .rk(rk_v[1]));
   key_exp_param #(.NK(8)) dut8 (
      .clk(clk), .rst(rst), .start(start_v[2]), .key(key8), .busy(busy_v[2]),
      .done(done_v[2]), .key_valid(kv_v[2]), .rk_idx(idx_v[2]), .rk(rk_v[2]));

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_key(input int d, input logic [255:0] k);
      case (d)
         0:       key4 = k[127:0];
         1:       key6 = k[191:0];
         default: key8 = k;
      endcase
   endtask

   // Pulse start for one edge; returns #1 after the start edge
   task automatic start_exp(input int d, input logic [255:0] k);
      @(negedge clk);
      set_key(d, k);
      start_v[d] = 1'b1;
      @(posedge clk);
      #1;
      start_v[d] = 1'b0;
   endtask

   // Count edges from the start edge until done is seen, then check the pulse width
   task automatic wait_done(input int d, input int lat, input string name);
      int n;
      n = 0;
      while (!done_v[d] && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({name, "_latency"}, 128'(n), 128'(lat));
      chk({name, "_busy_at_done"}, 128'(busy_v[d]), 128'(0));
      chk({name, "_valid_at_done"}, 128'(kv_v[d]), 128'(1));
      @(posedge clk);
      #1;
      chk({name, "_done_pulse"}, 128'(done_v[d]), 128'(0));
   endtask

   task automatic read_rk(input int d, input logic [3:0] idx, input logic [127:0] exp,
                          input string name);
      @(negedge clk);
      idx_v[d] = idx;
      #1;
      chk(name, rk_v[d], exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      int seen;

      tbl[0]  = '{0, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
      tbl[1]  = '{0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
      tbl[2]  = '{0, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
      tbl[3]  = '{0, 4'd10, T1_RK10};
      tbl[4]  = '{0, 4'd11, 128'h0};
      tbl[5]  = '{0, 4'd15, 128'h0};
      tbl[6]  = '{1, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5};
      tbl[7]  = '{1, 4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5};
      tbl[8]  = '{1, 4'd12, 128'he98ba06f448c773c8ecc720401002202};
      tbl[9]  = '{1, 4'd13, 128'h0};
      tbl[10] = '{2, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781};
      tbl[11] = '{2, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4};
      tbl[12] = '{2, 4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde};
      tbl[13] = '{2, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e};
      tbl[14] = '{2, 4'd15, 128'h0};

      rst     = 1'b1;
      start_v = '0;
      key4    = '0;
      key6    = '0;
      key8    = '0;
      for (int d = 0; d < 3; d++) idx_v[d] = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset_busy_%0d", d),  128'(busy_v[d]), 128'(0));
         chk($sformatf("reset_done_%0d", d),  128'(done_v[d]), 128'(0));
         chk($sformatf("reset_valid_%0d", d), 128'(kv_v[d]),   128'(0));
         chk($sformatf("reset_rk_%0d", d),    rk_v[d],         128'h0);
      end
      @(negedge clk);
      rst = 1'b0;

      // T1..T3: full expansions and latency per key length
      start_exp(0, 256'(T1_KEY));
      chk("t1_busy_after_start", 128'(busy_v[0]), 128'(1));
      wait_done(0, 40, "t1");
      start_exp(1, 256'(T2_KEY));
      wait_done(1, 46, "t2");
      start_exp(2, T3_KEY);
      wait_done(2, 52, "t3");

      for (int i = 0; i < 15; i++) begin
         read_rk(tbl[i].d, tbl[i].idx, tbl[i].exp,
                 $sformatf("rk_nk%0d_idx%0d", 4 + 2 * tbl[i].d, tbl[i].idx));
      end

      // T6 boundary: every index above NR reads zero
      for (int k = 11; k < 16; k++) read_rk(0, 4'(k), 128'h0, $sformatf("t6_oob_idx%0d", k));

      // T4: restart, then hold start with another key through the done edge
      start_exp(0, 256'(T1_KEY));
      chk("t4_valid_cleared", 128'(kv_v[0]), 128'(0));
      n = 0;
      while (!done_v[0] && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 10) begin
            key4       = '0;
            start_v[0] = 1'b1;
         end
      end
      start_v[0] = 1'b0;
      chk("t4_latency", 128'(n), 128'(40));
      @(posedge clk);
      #1;
      chk("t4_no_restart_busy", 128'(busy_v[0]), 128'(0));
      chk("t4_valid_kept", 128'(kv_v[0]), 128'(1));
      read_rk(0, 4'd10, T1_RK10, "t4_rk10");

      // T5: reset mid-expansion aborts without a done pulse
      start_exp(0, 256'(T1_KEY));
      repeat (20) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("t5_busy", 128'(busy_v[0]), 128'(0));
      chk("t5_valid", 128'(kv_v[0]), 128'(0));
      chk("t5_rk", rk_v[0], 128'h0);
      seen = 0;
      repeat (50) begin
         @(posedge clk);
         #1;
         if (done_v[0]) seen++;
      end
      chk("t5_no_done", 128'(seen), 128'(0));
      start_exp(0, 256'(T1_KEY));
      wait_done(0, 40, "t5_restart");
      read_rk(0, 4'd10, T1_RK10, "t5_rk10");
      read_rk(0, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605, "t5_rk1");

      // T6: all-zero key; key_valid drops on the start edge
      start_exp(0, 256'h0);
      chk("t6_valid_drop", 128'(kv_v[0]), 128'(0));
      chk("t6_rk_hidden", rk_v[0], 128'h0);
      wait_done(0, 40, "t6");
      read_rk(0, 4'd1,  128'h62636363626363636263636362636363, "t6_rk1");
      read_rk(0, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "t6_rk10");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
